// File: rtl/psum_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : psum_buffer_if
// Description : Handshake bundle between the conv adder, the partial-sum
//               buffer and the downstream pixel sink.
// Revision    : 1.0  initial release
// ============================================================================

`ifndef INTERNAL_BITS
`define INTERNAL_BITS 20
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

interface psum_buffer_if #(
  parameter int ADDR_BITS = 4
);
  logic                      start;
  logic [1:0]                mode_in;
  logic [ADDR_BITS:0]        num_pix;
  logic [1:0]                mode_out;
  logic [`INTERNAL_BITS-1:0] psum_out;
  logic                      res_valid;
  logic                      res_ready;
  logic [`INTERNAL_BITS-1:0] res_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [`DATA_BITS-1:0]     out_data;
  logic                      busy;
  logic                      done;

  modport slave (
    input  start, mode_in, num_pix, res_valid, res_in, out_ready,
    output mode_out, psum_out, res_ready, out_valid, out_data, busy, done
  );

  modport master (
    output start, mode_in, num_pix, res_valid, res_in, out_ready,
    input  mode_out, psum_out, res_ready, out_valid, out_data, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/psum_buffer.sv
`default_nettype none
// ============================================================================
// Module      : psum_buffer
// Description : Partial-sum register file on the conv adder return path;
//               feeds sums back per pass and drains saturated pixels after
//               the bias pass. Define PSUM_RELU_EN to zero negative drains.
// Revision    : 1.0  initial release
// ============================================================================

`ifndef INTERNAL_BITS
`define INTERNAL_BITS 20
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

module psum_buffer #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input wire logic       clk,
  input wire logic       rst,
  psum_buffer_if.slave   bus
);

  localparam int c_ibits = `INTERNAL_BITS;
  localparam int c_dbits = `DATA_BITS;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_accum = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  localparam logic [ADDR_BITS:0] c_depth = DEPTH[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] c_one   = {{ADDR_BITS{1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [1:0]            r_mode;
  logic [ADDR_BITS:0]    r_num;
  logic [ADDR_BITS:0]    r_wptr;
  logic [ADDR_BITS:0]    r_rptr;
  logic [c_ibits-1:0]    r_mem [DEPTH];

  logic                  w_start_ok;
  logic [ADDR_BITS:0]    w_num_clamp;
  logic                  w_res_acc;
  logic                  w_out_acc;
  logic                  w_last_w;
  logic                  w_last_r;
  logic [c_ibits-1:0]    w_rd;
  logic                  w_fits;
  logic                  w_neg;
  logic [c_dbits-1:0]    w_sat;

  assign w_start_ok  = bus.start && (bus.mode_in != 2'd3);
  assign w_num_clamp = (bus.num_pix > c_depth) ? c_depth : bus.num_pix;
  assign w_res_acc   = bus.res_valid && (r_state == c_accum);
  assign w_out_acc   = bus.out_ready && (r_state == c_drain);
  assign w_last_w    = (r_wptr == (r_num - c_one));
  assign w_last_r    = (r_rptr == (r_num - c_one));

  // The value fits in DATA_BITS when every bit above the output sign bit
  // matches that sign bit.
  assign w_rd   = r_mem[r_rptr[ADDR_BITS-1:0]];
  assign w_neg  = w_rd[c_ibits-1];
  assign w_fits = (&w_rd[c_ibits-1:c_dbits-1]) | ~(|w_rd[c_ibits-1:c_dbits-1]);

`ifdef PSUM_RELU_EN
  assign w_sat = w_neg  ? '0 :
                 w_fits ? w_rd[c_dbits-1:0] :
                          {1'b0, {(c_dbits-1){1'b1}}};
`else
  assign w_sat = w_fits ? w_rd[c_dbits-1:0] :
                 w_neg  ? {1'b1, {(c_dbits-1){1'b0}}} :
                          {1'b0, {(c_dbits-1){1'b1}}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle: begin
        if (w_start_ok) begin
          w_next = (w_num_clamp == '0) ? c_done : c_accum;
        end
      end
      c_accum: begin
        if (w_res_acc && w_last_w) begin
          w_next = (r_mode == 2'd2) ? c_drain : c_done;
        end
      end
      c_drain: begin
        if (w_out_acc && w_last_r) begin
          w_next = c_done;
        end
      end
      c_done:  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    bus.res_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.mode_out  = r_mode;
    bus.psum_out  = '0;
    bus.out_data  = '0;
    case (r_state)
      c_idle:  bus.busy = 1'b0;
      c_accum: begin
        bus.res_ready = 1'b1;
        // First pass starts from zero regardless of stale memory.
        if (r_mode != 2'd0) begin
          bus.psum_out = r_mem[r_wptr[ADDR_BITS-1:0]];
        end
      end
      c_drain: begin
        bus.out_valid = 1'b1;
        bus.out_data  = w_sat;
      end
      c_done:  bus.done = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 2'd0;
      r_num  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if ((r_state == c_idle) && w_start_ok) begin
        r_mode <= bus.mode_in;
        r_num  <= w_num_clamp;
        r_wptr <= '0;
      end
      if (w_res_acc) begin
        r_wptr <= r_wptr + c_one;
      end
      if ((r_state == c_accum) && (w_next == c_drain)) begin
        r_rptr <= '0;
      end
      if (w_out_acc) begin
        r_rptr <= r_rptr + c_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_res_acc) begin
      r_mem[r_wptr[ADDR_BITS-1:0]] <= bus.res_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_psum_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_buffer
// Description : Self-checking bench for psum_buffer (directed, table and
//               randomized passes against an array-based reference model).
// Revision    : 1.0  initial release
// ============================================================================

`ifndef INTERNAL_BITS
`define INTERNAL_BITS 20
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

module tb_psum_buffer;

  localparam int IB    = `INTERNAL_BITS;
  localparam int DB    = `DATA_BITS;
  localparam int DEPTH = 16;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_buffer_if #(.ADDR_BITS(4)) bus ();

  psum_buffer #(.DEPTH(DEPTH), .ADDR_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [IB-1:0] model [DEPTH];

  typedef struct {
    int          value;
    logic [DB-1:0] exp_out;
  } sat_vec_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference output rule: signed clamp into DATA_BITS, optional ReLU first.
  function automatic logic [DB-1:0] sat_ref(input logic [IB-1:0] v);
    int s;
    int hi;
    int lo;
    s  = int'($signed(v));
    hi = (1 << (DB - 1)) - 1;
    lo = -(1 << (DB - 1));
`ifdef PSUM_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return DB'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_pass(input int mode, input int num, input int adds[DEPTH],
                         input int gap, input int rdy, output logic [DB-1:0] last_out);
    int n;
    int acc;
    int cyc;
    int j;
    int k;
    bit v;
    bit r;
    logic [IB-1:0] exp_ps;
    n = (num > DEPTH) ? DEPTH : num;
    last_out = '0;
    bus.start   = 1'b1;
    bus.mode_in = mode[1:0];
    bus.num_pix = num[4:0];
    step();
    bus.start = 1'b0;
    if (mode == 3) begin
      check("ignored_busy", 32'(bus.busy), 0);
      step();
      check("ignored_busy2", 32'(bus.busy), 0);
      return;
    end
    if (n == 0) begin
      check("zero_done", 32'(bus.done), 1);
      check("zero_res_ready", 32'(bus.res_ready), 0);
      step();
      check("zero_idle", 32'(bus.busy), 0);
      return;
    end
    check("mode_out", 32'(bus.mode_out), 32'(mode));
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < BUDGET) begin
      check("res_ready", 32'(bus.res_ready), 1);
      if (gap == 0)      v = 1'b1;
      else if (gap == 1) v = (cyc % 2 == 0);
      else               v = 1'($urandom_range(0, 1));
      if (v) begin
        exp_ps = (mode == 0) ? '0 : model[acc];
        check("psum_out", 32'(bus.psum_out), 32'(exp_ps));
        bus.res_in = IB'(int'($signed(exp_ps)) + adds[acc]);
        model[acc] = bus.res_in;
        acc++;
      end else begin
        bus.res_in = IB'($urandom);
      end
      bus.res_valid = v;
      step();
      cyc++;
    end
    bus.res_valid = 1'b0;
    if (acc < n) check("accum_timeout", 32'(acc), 32'(n));
    check("accept_count_ready_low", 32'(bus.res_ready), 0);
    if (mode == 2) begin
      j = 0;
      k = 0;
      while (j < n && k < BUDGET) begin
        check("out_valid", 32'(bus.out_valid), 1);
        check("out_data", 32'(bus.out_data), 32'(sat_ref(model[j])));
        if (rdy == 0)      r = 1'b1;
        else if (rdy == 1) r = (k % 4 == 0) || (k % 4 == 3);
        else               r = 1'($urandom_range(0, 1));
        bus.out_ready = r;
        if (r) begin
          last_out = bus.out_data;
          j++;
        end
        step();
        k++;
      end
      bus.out_ready = 1'b0;
      if (j < n) check("drain_timeout", 32'(j), 32'(n));
      check("drain_end_valid", 32'(bus.out_valid), 0);
    end
    check("done_pulse", 32'(bus.done), 1);
    check("done_busy", 32'(bus.busy), 1);
    step();
    check("done_clear", 32'(bus.done), 0);
    check("idle_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    int adds[DEPTH];
    logic [DB-1:0] lo;
    sat_vec_t tbl[9];

    tbl[0] = '{300,     8'd127};
    tbl[1] = '{127,     8'd127};
    tbl[2] = '{128,     8'd127};
    tbl[3] = '{5,       8'd5};
    tbl[4] = '{0,       8'd0};
    tbl[5] = '{524287,  8'd127};
`ifdef PSUM_RELU_EN
    tbl[6] = '{-300,    8'd0};
    tbl[7] = '{-128,    8'd0};
    tbl[8] = '{-524288, 8'd0};
`else
    tbl[6] = '{-300,    8'h80};
    tbl[7] = '{-128,    8'h80};
    tbl[8] = '{-524288, 8'h80};
`endif

    bus.start = 1'b0; bus.mode_in = 2'd0; bus.num_pix = '0;
    bus.res_valid = 1'b0; bus.res_in = '0; bus.out_ready = 1'b0;

    step();
    step();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_res_ready", 32'(bus.res_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_mode_out", 32'(bus.mode_out), 0);
    rst = 1'b0;
    step();

    // Oversized count clamps to DEPTH and defines every entry of the model.
    for (int i = 0; i < DEPTH; i++) adds[i] = i * 3 - 7;
    do_pass(0, DEPTH + 3, adds, 0, 0, lo);

    // Three-pass accumulation with bias 100 on the last pass.
    for (int i = 0; i < DEPTH; i++) adds[i] = i + 1;
    do_pass(0, 4, adds, 0, 0, lo);
    for (int i = 0; i < DEPTH; i++) adds[i] = 10;
    do_pass(1, 4, adds, 0, 0, lo);
    for (int i = 0; i < DEPTH; i++) adds[i] = 100;
    do_pass(2, 4, adds, 0, 0, lo);
    check("three_pass_last", 32'(lo), 32'd114);
    check("three_pass_model0", 32'(model[0]), 32'd111);

    // Backpressure 1,0,0,1 during drain.
    for (int i = 0; i < DEPTH; i++) adds[i] = 7 * i - 20;
    do_pass(2, 6, adds, 0, 1, lo);

    // Alternating result gaps.
    for (int i = 0; i < DEPTH; i++) adds[i] = 2 * i + 1;
    do_pass(1, 9, adds, 1, 0, lo);

    do_pass(0, 0, adds, 0, 0, lo);
    do_pass(3, 4, adds, 0, 0, lo);

    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < DEPTH; i++) adds[i] = 0;
      adds[0] = tbl[t].value - int'($signed(model[0]));
      do_pass(2, 1, adds, 0, 0, lo);
      check("sat_table", 32'(lo), 32'(tbl[t].exp_out));
    end

    // Reset in DRAIN abandons the pass without a done pulse.
    for (int i = 0; i < DEPTH; i++) adds[i] = 1;
    bus.start = 1'b1; bus.mode_in = 2'd2; bus.num_pix = 5'd4;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rstseq_psum", 32'(bus.psum_out), 32'(model[i]));
      bus.res_in = IB'(int'($signed(model[i])) + 1);
      model[i] = bus.res_in;
      bus.res_valid = 1'b1;
      step();
    end
    bus.res_valid = 1'b0;
    check("rstseq_in_drain", 32'(bus.out_valid), 1);
    rst = 1'b1;
    step();
    check("rstseq_out_valid", 32'(bus.out_valid), 0);
    check("rstseq_busy", 32'(bus.busy), 0);
    check("rstseq_done", 32'(bus.done), 0);
    step();
    rst = 1'b0;
    check("rstseq_done2", 32'(bus.done), 0);
    step();
    check("rstseq_done3", 32'(bus.done), 0);
    check("rstseq_idle", 32'(bus.busy), 0);

    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < DEPTH; i++) adds[i] = int'($urandom_range(0, 400)) - 200;
      do_pass(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)), adds,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), lo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
